// File: rtl/date_overlay_mux.sv
// Pixel assembly, date overlay and output FIFO between the date writer and the colour converter.
// Optional macro DATE_OVR_BLEND_EN: overlaid pixels are a 50% blend instead of a replacement.
module date_overlay_mux #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  DATE_R     = 8'hFF,
    parameter logic [7:0]  DATE_G     = 8'hFF,
    parameter logic [7:0]  DATE_B     = 8'hFF
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [31:0] line_width,
    input  logic        rgb_valid,
    input  logic [7:0]  rgb_data,
    input  logic        date_ovr_en,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic        pix_eol,
    output logic        ovf
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]    comp;
    logic [7:0]    r_q, g_q;
    logic          ovr_acc;
    logic [31:0]   col;
    logic [24:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          push, pop, full, wr_en, overlay, eol;
    logic [23:0]   pix_in;

    assign push    = rgb_valid && (comp == 2'd2);
    assign pop     = pix_valid && pix_ready;
    assign full    = (count == CW'(FIFO_DEPTH));
    // A full FIFO still accepts the new pixel when the head leaves on the same edge.
    assign wr_en   = push && (!full || pop);
    assign overlay = ovr_acc | date_ovr_en;
    assign eol     = (line_width <= 32'd1) || (col == line_width - 32'd1);

`ifdef DATE_OVR_BLEND_EN
    function automatic logic [7:0] blend(input logic [7:0] a, input logic [7:0] b);
        return (a >> 1) + (b >> 1);
    endfunction

    assign pix_in = overlay ? {blend(r_q, DATE_R), blend(g_q, DATE_G), blend(rgb_data, DATE_B)}
                            : {r_q, g_q, rgb_data};
`else
    assign pix_in = overlay ? {DATE_R, DATE_G, DATE_B} : {r_q, g_q, rgb_data};
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            comp    <= 2'd0;
            r_q     <= 8'h00;
            g_q     <= 8'h00;
            ovr_acc <= 1'b0;
            col     <= 32'd0;
        end else begin
            if (rgb_valid) begin
                case (comp)
                    2'd0:    begin r_q <= rgb_data; comp <= 2'd1; end
                    2'd1:    begin g_q <= rgb_data; comp <= 2'd2; end
                    default: comp <= 2'd0;
                endcase
            end
            ovr_acc <= push ? 1'b0 : (ovr_acc | date_ovr_en);
            // Column tracks the line even when the pixel itself is dropped.
            if (push) col <= eol ? 32'd0 : col + 32'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (pop)   rptr <= rptr + PW'(1);
            if (push && full && !pop) ovf <= 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wptr] <= {pix_in, eol};
    end

    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? mem[rptr][24:1] : 24'h0;
    assign pix_eol   = pix_valid ? mem[rptr][0] : 1'b0;
endmodule

// File: tb/tb_date_overlay_mux.sv
// Bench for date_overlay_mux: queue-based pixel model plus directed and random scenarios.
module tb_date_overlay_mux;
    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [31:0] line_width;
    logic        rgb_valid;
    logic [7:0]  rgb_data;
    logic        date_ovr_en;
    logic        pix_ready;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_eol;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    date_overlay_mux #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst(rst), .line_width(line_width),
        .rgb_valid(rgb_valid), .rgb_data(rgb_data), .date_ovr_en(date_ovr_en),
        .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_eol(pix_eol), .ovf(ovf)
    );

    always #5 clk_in = ~clk_in;

    // Model: partial pixel bytes, FIFO contents {data,eol}, pending overlay, column, sticky overflow.
    logic [7:0]  part_q[$];
    logic [24:0] fifo_q[$];
    logic [24:0] got_q[$];
    bit          m_ovr, m_ovf;
    int unsigned m_col;

    function automatic logic [26:0] exp_vec();
        if (fifo_q.size() == 0) return {1'b0, 24'h0, 1'b0, m_ovf};
        return {1'b1, fifo_q[0], m_ovf};
    endfunction

    task automatic model_reset();
        part_q.delete();
        fifo_q.delete();
        m_ovr = 0;
        m_ovf = 0;
        m_col = 0;
    endtask

    task automatic do_reset(input logic [31:0] lw);
        rst = 1'b1; rgb_valid = 1'b0; rgb_data = 8'h00; date_ovr_en = 1'b0; pix_ready = 1'b0;
        line_width = lw;
        model_reset();
        @(posedge clk_in); #1;
        rst = 1'b0;
        got_q.delete();
    endtask

    // One clock: drive inputs, advance the model, record what the DUT handed over.
    task automatic tick(input logic v, input logic [7:0] d, input logic o, input logic r);
        int pre;
        bit pop, pushing;
        logic [24:0] ent;
        rgb_valid = v; rgb_data = d; date_ovr_en = o; pix_ready = r;
        pre = fifo_q.size();
        pop = (pre > 0) && r;
        pushing = 0;
        ent = '0;
        if (pop) got_q.push_back({pix_data, pix_eol});
        if (v && part_q.size() == 2) begin
            bit ovl = m_ovr | o;
            bit e = (line_width <= 32'd1) || (m_col == line_width - 32'd1);
            logic [23:0] px = {part_q[0], part_q[1], d};
            if (ovl) begin
`ifdef DATE_OVR_BLEND_EN
                px = {(px[23:16] >> 1) + 8'h7F, (px[15:8] >> 1) + 8'h7F, (px[7:0] >> 1) + 8'h7F};
`else
                px = 24'hFFFFFF;
`endif
            end
            ent = {px, e};
            m_col = e ? 0 : m_col + 1;
            m_ovr = 0;
            part_q.delete();
            pushing = 1;
        end else begin
            if (v) part_q.push_back(d);
            m_ovr = m_ovr | o;
        end
        if (pop) void'(fifo_q.pop_front());
        if (pushing) begin
            if (pre < DEPTH || pop) fifo_q.push_back(ent);
            else m_ovf = 1;
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rgb_valid = 1'b0; rgb_data = 8'h00; date_ovr_en = 1'b0; pix_ready = 1'b0;
        line_width = 32'd4;
        model_reset();
        #1;
        total++;
        if ({pix_valid, pix_data, pix_eol, ovf} !== 27'h0) begin
            bad++; $display("FAIL reset_async got=%h exp=0", {pix_valid, pix_data, pix_eol, ovf});
        end
        @(posedge clk_in); #1;
        rst = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if ({pix_valid, pix_data, pix_eol, ovf} !== 27'h0) begin
            bad++; $display("FAIL reset_idle got=%h exp=0", {pix_valid, pix_data, pix_eol, ovf});
        end
    endtask

    task automatic test_stream(input bit with_ovr);
        logic [24:0] e1 [4];
        e1[0] = {24'h101112, 1'b0};
        e1[1] = {24'h131415, 1'b0};
        e1[2] = {24'h161718, 1'b0};
        e1[3] = {24'h191A1B, 1'b1};
        if (with_ovr) begin
`ifdef DATE_OVR_BLEND_EN
            e1[1] = {24'h888989, 1'b0};
`else
            e1[1] = {24'hFFFFFF, 1'b0};
`endif
        end
        do_reset(32'd4);
        for (int i = 0; i < 15; i++) begin
            logic [7:0] b = 8'h10 + i[7:0];
            tick(i < 12, b, with_ovr && (i == 4), 1'b1);
            total++;
            if ({pix_valid, pix_data, pix_eol, ovf} !== exp_vec()) begin
                bad++; $display("FAIL stream%0d cyc%0d got=%h exp=%h", with_ovr, i,
                                {pix_valid, pix_data, pix_eol, ovf}, exp_vec());
            end
            if (i == 2) begin
                total++;
                if (pix_valid !== 1'b1 || pix_data !== 24'h101112) begin
                    bad++; $display("FAIL first_latency got=%b/%h exp=1/101112", pix_valid, pix_data);
                end
            end
        end
        total++;
        if (got_q.size() != 4) begin
            bad++; $display("FAIL stream%0d_count got=%0d exp=4", with_ovr, got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got_q[k] !== e1[k]) begin
                    bad++; $display("FAIL stream%0d_pix%0d got=%h exp=%h", with_ovr, k, got_q[k], e1[k]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset(32'd4);
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 8'h20 + i[7:0], 1'b0, 1'b0);
            total++;
            if ({pix_valid, pix_data, pix_eol, ovf} !== exp_vec()) begin
                bad++; $display("FAIL overflow cyc%0d got=%h exp=%h", i,
                                {pix_valid, pix_data, pix_eol, ovf}, exp_vec());
            end
        end
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL overflow_flag got=%b exp=1", ovf); end
        for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (got_q.size() != 4 || pix_valid !== 1'b0 || ovf !== 1'b1) begin
            bad++; $display("FAIL overflow_drain got=%0d/%b/%b exp=4/0/1", got_q.size(), pix_valid, ovf);
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b = 8'h20 + 8'(3 * k);
                logic [24:0] e = {b, b + 8'd1, b + 8'd2, k == 3};
                total++;
                if (got_q[k] !== e) begin
                    bad++; $display("FAIL overflow_pix%0d got=%h exp=%h", k, got_q[k], e);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        do_reset(32'd8);
        for (int i = 0; i < 15; i++) tick(1'b1, 8'h40 + i[7:0], 1'b0, i == 14);
        total++;
        if (ovf !== 1'b0 || pix_valid !== 1'b1) begin
            bad++; $display("FAIL full_pop_ovf got=%b/%b exp=0/1", ovf, pix_valid);
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (got_q.size() != 5 || ovf !== 1'b0) begin
            bad++; $display("FAIL full_pop_count got=%0d/%b exp=5/0", got_q.size(), ovf);
        end else begin
            for (int k = 0; k < 5; k++) begin
                logic [7:0] b = 8'h40 + 8'(3 * k);
                total++;
                if (got_q[k][24:1] !== {b, b + 8'd1, b + 8'd2}) begin
                    bad++; $display("FAIL full_pop_pix%0d got=%h exp=%h", k, got_q[k][24:1],
                                    {b, b + 8'd1, b + 8'd2});
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset(32'd2);
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        tick(1'b1, 8'h22, 1'b0, 1'b0);
        tick(1'b1, 8'h33, 1'b0, 1'b0);
        tick(1'b1, 8'h44, 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        rst = 1'b1; rgb_valid = 1'b0;
        #1;
        total++;
        if ({pix_valid, pix_data, pix_eol, ovf} !== 27'h0) begin
            bad++; $display("FAIL rst_mid_outputs got=%h exp=0", {pix_valid, pix_data, pix_eol, ovf});
        end
        @(posedge clk_in); #1;
        rst = 1'b0;
        model_reset();
        got_q.delete();
        tick(1'b1, 8'hAA, 1'b0, 1'b1);
        tick(1'b1, 8'hBB, 1'b0, 1'b1);
        tick(1'b1, 8'hCC, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if (got_q.size() != 1 || got_q[0] !== {24'hAABBCC, 1'b0}) begin
            bad++; $display("FAIL rst_mid_pixel got=%0d/%h exp=1/%h", got_q.size(),
                            (got_q.size() > 0) ? got_q[0] : 25'h0, {24'hAABBCC, 1'b0});
        end
    endtask

    task automatic test_gapped();
        logic        pv;
        logic [24:0] pd;
        bit          r;
        do_reset(32'd2);
        for (int c = 0; c < 48; c++) begin
            pv = pix_valid;
            pd = {pix_data, pix_eol};
            r = (c >= 36) ? 1'b1 : 1'($urandom_range(0, 1));
            tick((c % 3 == 0) && (c < 36), 8'h60 + 8'(c / 3), 1'b0, r);
            total++;
            if ({pix_valid, pix_data, pix_eol, ovf} !== exp_vec()) begin
                bad++; $display("FAIL gapped cyc%0d got=%h exp=%h", c,
                                {pix_valid, pix_data, pix_eol, ovf}, exp_vec());
            end
            if (pv && !r) begin
                total++;
                if (pix_valid !== 1'b1 || {pix_data, pix_eol} !== pd) begin
                    bad++; $display("FAIL gapped_hold cyc%0d got=%h exp=%h", c, {pix_data, pix_eol}, pd);
                end
            end
        end
        total++;
        if (got_q.size() != 4 || got_q[0][0] !== 1'b0 || got_q[1][0] !== 1'b1 ||
            got_q[2][0] !== 1'b0 || got_q[3][0] !== 1'b1) begin
            bad++; $display("FAIL gapped_eol got_n=%0d exp=4 with eol on 2,4", got_q.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] lws [4];
        lws[0] = 32'd0; lws[1] = 32'd1; lws[2] = 32'd3; lws[3] = 32'd5;
        for (int t = 0; t < 4; t++) begin
            do_reset(lws[t]);
            for (int c = 0; c < 400; c++) begin
                tick($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 1) == 1);
                total++;
                if ({pix_valid, pix_data, pix_eol, ovf} !== exp_vec()) begin
                    bad++; $display("FAIL random lw%0d cyc%0d got=%h exp=%h", lws[t], c,
                                    {pix_valid, pix_data, pix_eol, ovf}, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_overflow();
        test_full_pop();
        test_rst_mid();
        test_gapped();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
